// File: rtl/shr_seq.sv
// shr_seq: word-serial in-place one-bit right shift of a multi-word operand.
// Word 0 is the most significant word; the carry ripples from word k into the
// MSB of word k+1. Each word takes two cycles: READ issues the address to the
// synchronous RAM, WRITE consumes the returned data and writes the shifted word.
//
// Handshake: start is a one-cycle request that is accepted only while ready = 1;
// ready drops on the following cycle and rises again once carry_out is valid.

// One-bit right shift stage: carry_in enters at the MSB, the LSB leaves.
module shr #(
    parameter int OPW = 32
) (
    input  logic [OPW-1:0] a,
    input  logic           carry_in,
    output logic [OPW-1:0] adiv2,
    output logic           carry_out
);

    // Pure wiring, no state.
    always_comb begin
        adiv2     = {carry_in, a[OPW-1:1]};
        carry_out = a[0];
    end

endmodule

module shr_seq #(
    parameter int OPW = 32,
    parameter int ADW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [ADW-1:0] length,
    input  logic           carry_in,
    output logic           ready,
    output logic           carry_out,
    output logic [ADW-1:0] mem_addr,
    input  logic [OPW-1:0] mem_rd_data,
    output logic           mem_wr_en,
    output logic [OPW-1:0] mem_wr_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADW-1:0] ADDR_ONE = {{(ADW-1){1'b0}}, 1'b1};

    logic [1:0]     state;
    logic [ADW-1:0] len_reg;
    logic [ADW-1:0] addr_reg;
    logic           carry_reg;
    logic           carry_out_reg;
    logic           ready_reg;

    logic [OPW-1:0] shr_adiv2;
    logic           shr_carry;

    // The shift stage always sees the RAM data; it is only used in WRITE.
    shr #(.OPW(OPW)) u_shr (
        .a         (mem_rd_data),
        .carry_in  (carry_reg),
        .adiv2     (shr_adiv2),
        .carry_out (shr_carry)
    );

    // Sequencer state and operand bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            len_reg       <= '0;
            addr_reg      <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_reg   <= length;
                        carry_reg <= carry_in;
                        addr_reg  <= '0;
                        ready_reg <= 1'b0;
                        state     <= (length != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    carry_reg <= shr_carry;
                    addr_reg  <= addr_reg + ADDR_ONE;
                    // length >= 1 here, so len_reg - 1 cannot underflow.
                    state     <= (addr_reg == (len_reg - ADDR_ONE)) ? DONE : READ;
                end
                DONE: begin
                    carry_out_reg <= carry_reg;
                    ready_reg     <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port decode from the current state; idle values are all zero so
    // an asynchronous reset silences the port immediately.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            READ: begin
                mem_addr = addr_reg;
            end
            WRITE: begin
                mem_addr    = addr_reg;
                mem_wr_en   = 1'b1;
                mem_wr_data = shr_adiv2;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    // Status outputs are straight register copies.
    always_comb begin
        ready     = ready_reg;
        carry_out = carry_out_reg;
    end

endmodule

// File: tb/tb_shr_seq.sv
// Directed bench for shr_seq with a synchronous RAM model and a write monitor.
module tb_shr_seq;

    localparam int OPW = 32;
    localparam int ADW = 8;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [ADW-1:0] length;
    logic           carry_in;
    logic           ready;
    logic           carry_out;
    logic [ADW-1:0] mem_addr;
    logic [OPW-1:0] mem_rd_data;
    logic           mem_wr_en;
    logic [OPW-1:0] mem_wr_data;

    logic [OPW-1:0] mem [256];
    logic [OPW-1:0] init_img [256];
    logic           load_req;

    int edge_n;
    int wr_cnt;
    int wr_q[$];
    int consec_wr;
    logic prev_wr;

    int pass_cnt;
    int total_cnt;

    shr_seq #(.OPW(OPW), .ADW(ADW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .length      (length),
        .carry_in    (carry_in),
        .ready       (ready),
        .carry_out   (carry_out),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, with a one-cycle bulk preload from init_img.
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
        end
    end

    // Write monitor: absolute edge of every write and back-to-back detection.
    initial begin
        edge_n    = 0;
        wr_cnt    = 0;
        consec_wr = 0;
        prev_wr   = 1'b0;
    end
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (mem_wr_en) begin
            wr_cnt = wr_cnt + 1;
            wr_q.push_back(edge_n);
            if (prev_wr) consec_wr = consec_wr + 1;
        end
        prev_wr = mem_wr_en;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_mem();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Launch one operation and wait for ready. busy_at > 0 pulses a conflicting
    // start in that cycle. Returns the first cycle ready reads 1, the start edge
    // and the write-queue index at launch.
    task automatic run_op(input logic [ADW-1:0] l, input logic cin, input int busy_at,
                          output int rdy_cyc, output int st_edge, output int q_base);
        int c;
        q_base   = wr_q.size();
        start    = 1'b1;
        length   = l;
        carry_in = cin;
        @(posedge clk);
        #1;
        st_edge  = edge_n;
        start    = 1'b0;
        length   = ADW'($urandom_range(255, 0));
        carry_in = 1'($urandom_range(1, 0));
        c = 1;
        chk("ready_low_after_start", {63'd0, ready}, 64'd0);
        while (!ready && c < 600) begin
            if (c == busy_at) begin
                start    = 1'b1;
                length   = 8'd2;
                carry_in = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            c++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
        rdy_cyc = c;
    endtask

    logic [8159:0] big_in;
    logic [8159:0] big_exp;
    logic [8159:0] big_got;

    initial begin
        int rc, se, qb, wb;
        logic full_cin;

        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        length    = '0;
        carry_in  = 1'b0;
        load_req  = 1'b0;
        for (int i = 0; i < 256; i++) init_img[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",     {63'd0, ready},     64'd1);
        chk("rst_carry_out", {63'd0, carry_out}, 64'd0);
        chk("rst_mem_addr",  {56'd0, mem_addr},  64'd0);
        chk("rst_wr_en",     {63'd0, mem_wr_en}, 64'd0);
        chk("rst_wr_data",   {32'd0, mem_wr_data}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word
        init_img[0] = 32'h0000_0003;
        load_mem();
        wb = wr_cnt;
        run_op(8'd1, 1'b0, 0, rc, se, qb);
        chk("single_word",      {32'd0, mem[0]},  64'h1);
        chk("single_carry_out", {63'd0, carry_out}, 64'd1);
        chk("single_ready_cyc", 64'(rc), 64'd4);
        chk("single_writes",    64'(wr_cnt - wb), 64'd1);

        // Carry chain across two words
        init_img[0] = 32'h0000_0001;
        init_img[1] = 32'h0000_0003;
        load_mem();
        wb = wr_cnt;
        run_op(8'd2, 1'b1, 0, rc, se, qb);
        chk("chain_w0",        {32'd0, mem[0]}, 64'h8000_0000);
        chk("chain_w1",        {32'd0, mem[1]}, 64'h8000_0001);
        chk("chain_carry_out", {63'd0, carry_out}, 64'd1);
        chk("chain_writes",    64'(wr_cnt - wb), 64'd2);
        chk("chain_ready_cyc", 64'(rc), 64'd6);
        if (wr_q.size() >= qb + 2) begin
            chk("chain_wr_edge0", 64'(wr_q[qb] - se),     64'd2);
            chk("chain_wr_edge1", 64'(wr_q[qb + 1] - se), 64'd4);
        end else begin
            chk("chain_wr_edges_present", 64'(wr_q.size() - qb), 64'd2);
        end

        // Zero length, both carry values
        wb = wr_cnt;
        run_op(8'd0, 1'b0, 0, rc, se, qb);
        chk("zero_c0_carry_out", {63'd0, carry_out}, 64'd0);
        chk("zero_c0_ready_cyc", 64'(rc), 64'd2);
        run_op(8'd0, 1'b1, 0, rc, se, qb);
        chk("zero_c1_carry_out", {63'd0, carry_out}, 64'd1);
        chk("zero_c1_ready_cyc", 64'(rc), 64'd2);
        chk("zero_writes",       64'(wr_cnt - wb), 64'd0);
        chk("zero_mem_untouched", {32'd0, mem[0]}, 64'h8000_0000);

        // Busy start ignored during a four-word shift
        init_img[0] = 32'h1234_5678;
        init_img[1] = 32'h9ABC_DEF0;
        init_img[2] = 32'h0F0F_0F0F;
        init_img[3] = 32'hFFFF_FFFF;
        load_mem();
        wb = wr_cnt;
        run_op(8'd4, 1'b0, 3, rc, se, qb);
        chk("busy_w0", {32'd0, mem[0]}, 64'h091A_2B3C);
        chk("busy_w1", {32'd0, mem[1]}, 64'h4D5E_6F78);
        chk("busy_w2", {32'd0, mem[2]}, 64'h0787_8787);
        chk("busy_w3", {32'd0, mem[3]}, 64'hFFFF_FFFF);
        chk("busy_carry_out", {63'd0, carry_out}, 64'd1);
        chk("busy_writes",    64'(wr_cnt - wb), 64'd4);
        chk("busy_ready_cyc", 64'(rc), 64'd10);
        @(posedge clk);
        #1;
        chk("busy_no_relaunch", {63'd0, ready}, 64'd1);

        // Reset in cycle 5 of a four-word shift
        init_img[0] = 32'h0000_0003;
        init_img[1] = 32'h0000_0005;
        init_img[2] = 32'hAAAA_AAAA;
        init_img[3] = 32'h5555_5555;
        load_mem();
        wb = wr_cnt;
        start    = 1'b1;
        length   = 8'd4;
        carry_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_ready",     {63'd0, ready},       64'd1);
        chk("midrst_carry_out", {63'd0, carry_out},   64'd0);
        chk("midrst_mem_addr",  {56'd0, mem_addr},    64'd0);
        chk("midrst_wr_en",     {63'd0, mem_wr_en},   64'd0);
        chk("midrst_wr_data",   {32'd0, mem_wr_data}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_writes", 64'(wr_cnt - wb), 64'd2);
        chk("midrst_w0", {32'd0, mem[0]}, 64'h8000_0001);
        chk("midrst_w1", {32'd0, mem[1]}, 64'h8000_0002);
        chk("midrst_w2", {32'd0, mem[2]}, 64'hAAAA_AAAA);
        chk("midrst_w3", {32'd0, mem[3]}, 64'h5555_5555);

        // Follow-up operation on the partially shifted operand
        run_op(8'd4, 1'b0, 0, rc, se, qb);
        chk("after_w0", {32'd0, mem[0]}, 64'h4000_0000);
        chk("after_w1", {32'd0, mem[1]}, 64'hC000_0001);
        chk("after_w2", {32'd0, mem[2]}, 64'h5555_5555);
        chk("after_w3", {32'd0, mem[3]}, 64'h2AAA_AAAA);
        chk("after_carry_out", {63'd0, carry_out}, 64'd1);

        // Full length random operand against the wide reference shift
        for (int i = 0; i < 255; i++) init_img[i] = $urandom;
        init_img[255] = 32'hDEAD_BEEF;
        load_mem();
        full_cin = 1'($urandom_range(1, 0));
        for (int i = 0; i < 255; i++) big_in[8159 - 32 * i -: 32] = init_img[i];
        big_exp = {full_cin, big_in[8159:1]};
        wb = wr_cnt;
        run_op(8'd255, full_cin, 0, rc, se, qb);
        for (int i = 0; i < 255; i++) big_got[8159 - 32 * i -: 32] = mem[i];
        total_cnt++;
        assert (big_got === big_exp) pass_cnt++;
        else $error("FAIL full_operand: got msw 0x%0h lsw 0x%0h expected msw 0x%0h lsw 0x%0h",
                    big_got[8159:8128], big_got[31:0], big_exp[8159:8128], big_exp[31:0]);
        chk("full_carry_out", {63'd0, carry_out}, {63'd0, big_in[0]});
        chk("full_writes",    64'(wr_cnt - wb), 64'd255);
        chk("full_ready_cyc", 64'(rc), 64'd512);
        chk("full_beyond_end", {32'd0, mem[255]}, 64'hDEAD_BEEF);

        chk("no_back_to_back_writes", 64'(consec_wr), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shr_seq.md
# shr_seq

Word-serial sequencer that right-shifts a multi-word operand held in operand memory by one bit, in place. It walks the operand from the most significant word to the least significant, feeding each word through the one-bit `shr` stage (instantiated internally) and chaining that stage's carry from word to word. It sits in front of `shr` inside the `montprod` datapath of the modexp core and performs the `s = s >> 1` step of each Montgomery iteration.

## Interface
- `OPW`, 32, operand word width in bits
- `ADW`, 8, word-address width; the maximum operand length is 2^ADW − 1 words
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that launches a shift; sampled only when `ready` = 1
- `length`  in  ADW  operand length in words; sampled with `start`
- `carry_in`  in  1  bit shifted into the MSB of word 0
- `ready`  out  1  high when idle; low while a shift is in progress
- `carry_out`  out  1  LSB shifted out of the last word; valid while `ready` = 1
- `mem_addr`  out  ADW  word address; word 0 is the most significant word
- `mem_rd_data`  in  OPW  read data; valid one cycle after `mem_addr` is driven (synchronous RAM)
- `mem_wr_en`  out  1  write strobe for `mem_addr`
- `mem_wr_data`  out  OPW  write data

## Operation
- Registers: `len_reg`, `addr_reg`, `carry_reg`, `carry_out_reg`, `ready_reg`, and a 2-bit FSM state.
- Reset values: `ready` = 1, `carry_out` = 0, `mem_addr` = 0, `mem_wr_en` = 0, `mem_wr_data` = 0, FSM = IDLE.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: on `start`, capture `length`→`len_reg`, `carry_in`→`carry_reg`, and clear `addr_reg`.
  - `ready` goes low.
  - Next state is READ if `length` ≠ 0, otherwise DONE.
- READ: drive `mem_addr` = `addr_reg` with `mem_wr_en` = 0. Next state is WRITE.
- WRITE: the internal `shr` gets `a` = `mem_rd_data` and `carry_in` = `carry_reg`.
  - Drive `mem_wr_en` = 1, `mem_addr` = `addr_reg`, and `mem_wr_data` = `adiv2` = {`carry_reg`, `mem_rd_data`[OPW−1:1]}.
  - Update `carry_reg` ← `mem_rd_data`[0] and `addr_reg` ← `addr_reg` + 1.
  - If `addr_reg` = `len_reg` − 1, go to DONE; otherwise go to READ.
- DONE: `carry_out_reg` ← `carry_reg` and `ready` ← 1. Next state is IDLE.
- `length` = 0: no memory reads or writes; `carry_out` = `carry_in`.
- Arithmetic: the address compare is ADW-bit unsigned, and `addr_reg` never wraps because `length` ≤ 2^ADW − 1.
- `start` while `ready` = 0 is ignored. `length` and `carry_in` changes after the start cycle have no effect.
- `carry_out` holds its value until the DONE of the next operation.
- `reset_n` low at any point, including mid-operation:
  - immediate return to IDLE with reset values;
  - no further writes; words already written stay modified.

## Timing
- Edge 0 samples `start`. READ of word k happens in cycle 2k+1 and WRITE of word k in cycle 2k+2, for k = 0 … L−1.
- DONE occurs in cycle 2L+1. `ready` = 1 and `carry_out` are valid from cycle 2L+2.
- Latency from start to ready is 2L+2 cycles; for L = 0 it is 2 cycles.
- A new `start` is accepted in the first cycle that `ready` reads 1.
- `mem_wr_en` is asserted for exactly L cycles per operation, never in two consecutive cycles.
- Each write address equals the read address of the preceding cycle.

## Test plan
- Single word: L=1, mem[0]=0x00000003, `carry_in`=0 → mem[0]=0x00000001, `carry_out`=1, `ready` back at cycle 4.
- Carry chain: L=2, mem={0x00000001, 0x00000003}, `carry_in`=1 → mem={0x80000000, 0x80000001}, `carry_out`=1; exactly 2 write strobes, at cycles 2 and 4.
- Zero length: L=0, `carry_in`=1 → no memory access, `carry_out`=1, `ready` high at cycle 2.
- Full length: L=255 with a random operand → memory equals the 8160-bit reference value {`carry_in`, operand}>>1, and `carry_out` equals the operand LSB.
- Busy start: pulse `start` with a different `length` during a L=4 operation → ignored; exactly 4 writes; result matches the first request.
- Reset mid-op: assert `reset_n`=0 in cycle 5 of a L=4 run → all outputs at reset values at once; mem[0..1] shifted and mem[2..3] untouched; a subsequent operation runs correctly.
